// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register. Issues one-cycle synchronous
// imem reads, buffers a read that lands during a decode stall, and redirects on ID-resolved jumps.
module fetch_stage #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ID_stall,
  input  logic                  redirect,
  input  logic [31:0]           redirect_target,
  output logic                  imem_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_data,
  output logic [31:0]           ID_Instruction,
  output logic [31:0]           ID_PCPlus4,
  output logic                  ID_valid
);

  logic [31:0] r_pc;
  logic        r_pend;
  logic [31:0] r_pend_pc4;
  logic        r_hold_v;
  logic [31:0] r_hold_data;
  logic [31:0] r_hold_pc4;
  logic        r_id_valid;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc4;

  logic        w_issue;
  logic [31:0] w_pc_plus4;

  assign w_issue    = ~Reset & ~ID_stall & ~redirect;
  assign w_pc_plus4 = r_pc + 32'd4;

  assign imem_en   = w_issue;
  assign imem_addr = r_pc[ADDR_WIDTH+1:2];

  assign ID_Instruction = r_id_instr;
  assign ID_PCPlus4     = r_id_pc4;
  assign ID_valid       = r_id_valid;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc        <= RESET_PC;
      r_pend      <= 1'b0;
      r_pend_pc4  <= 32'd0;
      r_hold_v    <= 1'b0;
      r_hold_data <= 32'd0;
      r_hold_pc4  <= 32'd0;
      r_id_valid  <= 1'b0;
      r_id_instr  <= 32'd0;
      r_id_pc4    <= 32'd0;
    end else if (ID_stall) begin
      // Memory output is transient, so an in-flight read is parked in the hold buffer.
      if (r_pend) begin
        r_hold_v    <= 1'b1;
        r_hold_data <= imem_data;
        r_hold_pc4  <= r_pend_pc4;
      end
      r_pend <= 1'b0;
    end else if (redirect) begin
      r_pc       <= redirect_target & ~32'd3;
      r_pend     <= 1'b0;
      r_hold_v   <= 1'b0;
      r_id_valid <= 1'b0;
      r_id_instr <= 32'd0;
    end else begin
      r_pc       <= w_pc_plus4;
      r_pend     <= 1'b1;
      r_pend_pc4 <= w_pc_plus4;
      if (r_hold_v) begin
        r_id_valid <= 1'b1;
        r_id_instr <= r_hold_data;
        r_id_pc4   <= r_hold_pc4;
        r_hold_v   <= 1'b0;
      end else if (r_pend) begin
        r_id_valid <= 1'b1;
        r_id_instr <= imem_data;
        r_id_pc4   <= r_pend_pc4;
      end else begin
        r_id_valid <= 1'b0;
        r_id_instr <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-edge expected IF/ID contents are queued by each
// scenario and popped against the DUT after every rising edge.
module tb_fetch_stage;

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic [31:0] pc4;
    logic        p;  // compare pc4 as well
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        ID_stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        imem_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data = 32'hDEAD_BEEF;
  logic [31:0] ID_Instruction;
  logic [31:0] ID_PCPlus4;
  logic        ID_valid;

  logic        w_reset = 1'b1;
  logic        w_stall = 1'b0;
  logic        w_redir = 1'b0;
  logic [31:0] w_target = 32'd0;
  logic        w_en;
  logic [3:0]  w_addr;
  logic [31:0] w_data = 32'hDEAD_BEEF;
  logic [31:0] w_ins;
  logic [31:0] w_pc4;
  logic        w_valid;

  always #5 Clk = ~Clk;

  fetch_stage u_dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .ID_stall       (ID_stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .ID_Instruction (ID_Instruction),
    .ID_PCPlus4     (ID_PCPlus4),
    .ID_valid       (ID_valid)
  );

  fetch_stage #(.ADDR_WIDTH(4), .RESET_PC(32'h0000_0038)) u_wrap (
    .Clk            (Clk),
    .Reset          (w_reset),
    .ID_stall       (w_stall),
    .redirect       (w_redir),
    .redirect_target(w_target),
    .imem_en        (w_en),
    .imem_addr      (w_addr),
    .imem_data      (w_data),
    .ID_Instruction (w_ins),
    .ID_PCPlus4     (w_pc4),
    .ID_valid       (w_valid)
  );

  // Word k holds 0x1000_0000+k; output is garbage on cycles without a read.
  always @(posedge Clk) begin
    imem_data <= imem_en ? 32'h1000_0000 + {22'd0, imem_addr} : 32'hDEAD_BEEF;
    w_data    <= w_en ? 32'h1000_0000 + {28'd0, w_addr} : 32'hDEAD_BEEF;
  end

  task automatic push_e(input logic v, input logic [31:0] ins, input logic [31:0] pc4,
                        input logic p);
    exp_t x;
    x.v = v; x.ins = ins; x.pc4 = pc4; x.p = p;
    sb.push_back(x);
  endtask

  task automatic push_w(input int k);
    push_e(1'b1, 32'h1000_0000 + k, 32'(4 * (k + 1)), 1'b1);
  endtask

  task automatic push_bub();
    push_e(1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    Reset = 1'b1; ID_stall = 1'b0; redirect = 1'b0; redirect_target = 32'd0;
    sb.delete();
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    n_checks += 5;
    if (ID_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_valid: got %b expected 0", ID_valid);
    end
    if (ID_Instruction !== 32'd0) begin
      n_errors++; $display("FAIL reset_instr: got %h expected 0", ID_Instruction);
    end
    if (ID_PCPlus4 !== 32'd0) begin
      n_errors++; $display("FAIL reset_pc4: got %h expected 0", ID_PCPlus4);
    end
    if (imem_en !== 1'b0) begin
      n_errors++; $display("FAIL reset_imem_en: got %b expected 0", imem_en);
    end
    if (imem_addr !== 10'd0) begin
      n_errors++; $display("FAIL reset_imem_addr: got %h expected 0", imem_addr);
    end
  endtask

  task automatic test_startup();
    do_reset();
    #1;
    n_checks++;
    if (imem_en !== 1'b1 || imem_addr !== 10'd0) begin
      n_errors++;
      $display("FAIL startup_issue: got en=%b addr=%h expected en=1 addr=0", imem_en, imem_addr);
    end
    push_bub();
    for (int k = 0; k < 5; k++) push_w(k);
    for (int i = 1; i <= 6; i++) begin
      @(posedge Clk); #1;
      e = sb.pop_front(); n_checks++;
      if (ID_valid !== e.v || ID_Instruction !== e.ins || (e.p && ID_PCPlus4 !== e.pc4)) begin
        n_errors++;
        $display("FAIL startup edge %0d: got v=%b ins=%h pc4=%h expected v=%b ins=%h pc4=%h",
                 i, ID_valid, ID_Instruction, ID_PCPlus4, e.v, e.ins, e.pc4);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    push_bub();
    for (int k = 0; k <= 5; k++) push_w(k);
    repeat (3) push_w(5);
    push_w(6);
    push_w(7);
    for (int i = 1; i <= 12; i++) begin
      ID_stall = (i >= 8 && i <= 10);
      @(posedge Clk); #1;
      e = sb.pop_front(); n_checks++;
      if (ID_valid !== e.v || ID_Instruction !== e.ins || (e.p && ID_PCPlus4 !== e.pc4)) begin
        n_errors++;
        $display("FAIL stall edge %0d: got v=%b ins=%h pc4=%h expected v=%b ins=%h pc4=%h",
                 i, ID_valid, ID_Instruction, ID_PCPlus4, e.v, e.ins, e.pc4);
      end
    end
    ID_stall = 1'b0;
  endtask

  task automatic test_redirect();
    do_reset();
    push_bub();
    for (int k = 0; k <= 3; k++) push_w(k);
    push_bub();
    push_bub();
    push_w(16);
    push_w(17);
    for (int i = 1; i <= 9; i++) begin
      redirect = (i == 6);
      redirect_target = 32'h0000_0042;  // low bits must be ignored
      #1;
      if (i == 6) begin
        n_checks++;
        if (imem_en !== 1'b0) begin
          n_errors++; $display("FAIL redirect_no_issue: got en=%b expected 0", imem_en);
        end
      end
      @(posedge Clk); #1;
      e = sb.pop_front(); n_checks++;
      if (ID_valid !== e.v || ID_Instruction !== e.ins || (e.p && ID_PCPlus4 !== e.pc4)) begin
        n_errors++;
        $display("FAIL redirect edge %0d: got v=%b ins=%h pc4=%h expected v=%b ins=%h pc4=%h",
                 i, ID_valid, ID_Instruction, ID_PCPlus4, e.v, e.ins, e.pc4);
      end
    end
    redirect = 1'b0;
  endtask

  task automatic test_stall_masks_redirect();
    do_reset();
    push_bub();
    for (int k = 0; k <= 2; k++) push_w(k);
    push_w(2);
    push_w(3);
    push_w(4);
    push_bub();
    push_bub();
    push_w(2);
    push_w(3);
    for (int i = 1; i <= 11; i++) begin
      ID_stall = (i == 5);
      redirect = (i == 5) || (i == 8);
      redirect_target = (i == 5) ? 32'h0000_0080 : 32'h0000_0008;
      #1;
      if (i == 5) begin
        n_checks++;
        if (imem_en !== 1'b0) begin
          n_errors++; $display("FAIL stall_redirect_no_issue: got en=%b expected 0", imem_en);
        end
      end
      @(posedge Clk); #1;
      e = sb.pop_front(); n_checks++;
      if (ID_valid !== e.v || ID_Instruction !== e.ins || (e.p && ID_PCPlus4 !== e.pc4)) begin
        n_errors++;
        $display("FAIL stall_redirect edge %0d: got v=%b ins=%h pc4=%h expected v=%b ins=%h pc4=%h",
                 i, ID_valid, ID_Instruction, ID_PCPlus4, e.v, e.ins, e.pc4);
      end
    end
    ID_stall = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    push_bub();
    for (int k = 0; k <= 2; k++) push_w(k);
    push_w(2);
    push_e(1'b0, 32'd0, 32'd0, 1'b1);
    push_bub();
    push_w(0);
    push_w(1);
    for (int i = 1; i <= 9; i++) begin
      ID_stall = (i == 5 || i == 6);
      Reset    = (i == 6);
      @(posedge Clk); #1;
      e = sb.pop_front(); n_checks++;
      if (ID_valid !== e.v || ID_Instruction !== e.ins || (e.p && ID_PCPlus4 !== e.pc4)) begin
        n_errors++;
        $display("FAIL reset_mid_stall edge %0d: got v=%b ins=%h pc4=%h expected v=%b ins=%h pc4=%h",
                 i, ID_valid, ID_Instruction, ID_PCPlus4, e.v, e.ins, e.pc4);
      end
    end
    ID_stall = 1'b0;
    Reset = 1'b0;
  endtask

  task automatic test_wrap();
    sb.delete();
    w_reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    n_checks += 2;
    if (w_en !== 1'b0) begin
      n_errors++; $display("FAIL wrap_reset_en: got %b expected 0", w_en);
    end
    if (w_addr !== 4'd14) begin
      n_errors++; $display("FAIL wrap_reset_addr: got %0d expected 14", w_addr);
    end
    w_reset = 1'b0;
    push_bub();
    push_e(1'b1, 32'h1000_000E, 32'h3C, 1'b1);
    push_e(1'b1, 32'h1000_000F, 32'h40, 1'b1);
    push_e(1'b1, 32'h1000_0000, 32'h44, 1'b1);
    push_e(1'b1, 32'h1000_0001, 32'h48, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      @(posedge Clk); #1;
      e = sb.pop_front(); n_checks++;
      if (w_valid !== e.v || w_ins !== e.ins || (e.p && w_pc4 !== e.pc4)) begin
        n_errors++;
        $display("FAIL wrap edge %0d: got v=%b ins=%h pc4=%h expected v=%b ins=%h pc4=%h",
                 i, w_valid, w_ins, w_pc4, e.v, e.ins, e.pc4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_stall_masks_redirect();
    test_reset_mid_stall();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register. It owns the PC and issues word reads to a synchronous one-cycle instruction memory. It presents the fetched instruction and PC+4 to the decode stage. It honours the decode-stage hazard stall (`ID_stall`) and redirects fetch on taken branches, jumps and JR resolved in ID.

## Interface
- `ADDR_WIDTH`, default 10: instruction-memory word-address width.
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Must be word aligned.

- `Clk`  in  1  rising-edge clock.
- `Reset`  in  1  synchronous, active-high reset.
- `ID_stall`  in  1  decode hazard stall. While high, the IF/ID contents and the PC are frozen.
- `redirect`  in  1  taken branch, J, JAL or JR resolved in ID this cycle.
- `redirect_target`  in  32  next fetch address; bits [1:0] are ignored.
- `imem_en`  out  1  read enable to the instruction memory.
- `imem_addr`  out  ADDR_WIDTH  word address, equal to PC[ADDR_WIDTH+1:2].
- `imem_data`  in  32  read data, valid on the cycle after an accepted read (`imem_en`=1).
- `ID_Instruction`  out  32  instruction in ID. Forced to 0 (NOP) when `ID_valid`=0.
- `ID_PCPlus4`  out  32  PC+4 of the instruction in ID. Used for branch targets and the JAL link.
- `ID_valid`  out  1  ID holds a real instruction.

## Operation
- **State:**
  - `PC` (32 bits).
  - `pend`: a read is in flight, with `pend_pc4`.
  - Hold buffer: `hold_v`, `hold_data`, `hold_pc4`.
  - IF/ID registers.
- **Fetch issue:**
  - `imem_en` = ~Reset & ~ID_stall & ~redirect.
  - On an issuing edge: `PC`<=`PC`+4 (mod 2^32), `pend`<=1, `pend_pc4`<=`PC`+4.
  - A non-issuing edge clears `pend`, except that a stall with `pend`=1 moves the data into the hold buffer (see Stall).
- **IF/ID load** (`ID_stall`=0, `redirect`=0):
  - Source priority: the hold buffer if `hold_v`, else `imem_data` if `pend`. Otherwise load a bubble (`ID_valid`<=0).
  - A hold-buffer load clears `hold_v`.
- **Stall** (`ID_stall`=1, `redirect`=0):
  - IF/ID registers and `PC` hold.
  - If `pend`=1, capture `imem_data` into the hold buffer: `hold_v`<=1, `pend`<=0.
  - The instruction memory output is not relied on to persist.
  - Only one read can be in flight, so the buffer never overflows.
- **Redirect** (`redirect`=1, `ID_stall`=0):
  - `PC`<=`redirect_target` & ~3.
  - `pend`<=0 and `hold_v`<=0; the wrong-path fetch is discarded.
  - `ID_valid`<=0.
  - There is no branch delay slot.
- **Redirect with `ID_stall`=1:** `redirect` is ignored and stall behaviour applies, because the ID operands are not yet valid. Decode re-asserts `redirect` once the stall clears.
- **Reset** overrides everything and is valid mid-stall or mid-redirect:
  - `PC`<=`RESET_PC`, `pend`<=0, `hold_v`<=0, `ID_valid`<=0.
  - `ID_Instruction`<=0, `ID_PCPlus4`<=0.
- **Wrap-around:**
  - `PC` wraps at 2^32.
  - `imem_addr` is a truncation, so fetch wraps modulo 2^ADDR_WIDTH words.
  - No fault is raised.

## Timing
- **Reset values:**
  - `ID_valid`=0, `ID_Instruction`=0, `ID_PCPlus4`=0.
  - `imem_en`=0 during reset.
  - `imem_addr` = RESET_PC[ADDR_WIDTH+1:2].
- **Start-up:**
  - Cycle 1 after reset release: issue at `RESET_PC`.
  - After the edge ending cycle 2: `ID_valid`=1 with that instruction.
- **Steady state:** one instruction per cycle. Latency from PC issue to ID is 2 edges.
- **Redirect penalty:**
  - Redirect edge → the target issues the next cycle → the target is in ID 2 edges after the redirect edge.
  - This gives exactly 2 bubble cycles in ID.
- **Stall of N cycles:**
  - ID holds the same instruction for N+1 cycles.
  - The first post-stall load comes from the hold buffer.
  - The stream resumes with no lost or duplicated instruction.
- **Outputs** are registered, except `imem_en` and `imem_addr`, which are combinational from `PC`, `ID_stall`, `redirect` and `Reset`.

## Test plan
- **Start-up:** memory word k = 32'h1000_0000+k, `RESET_PC`=0, release reset → `ID_valid` rises on the 2nd edge. ID then shows 0x1000_0000, 0x1000_0001, … with `ID_PCPlus4` = 4, 8, ….
- **Stall:** assert `ID_stall` for 3 cycles while word 5 is in ID → ID holds 0x1000_0005 (`ID_PCPlus4`=0x18) for 4 cycles, then words 6, 7 follow with no gap or duplicate.
- **Redirect:** pulse `redirect` with target 0x40 while word 3 is in ID → 2 bubble cycles (`ID_valid`=0, `ID_Instruction`=0), then 0x1000_0010 with `ID_PCPlus4`=0x44.
- **Stall masks redirect:** assert `redirect`=1 and `ID_stall`=1 together for 1 cycle, then deassert both → no redirect taken and sequential fetch continues. Then assert `redirect` alone with target 0x8 → 2 bubble cycles, then word 2.
- **Reset mid-stall:** assert `Reset` during a 2-cycle stall with `hold_v`=1 → next edge gives `ID_valid`=0 and an empty hold buffer. After release, start-up repeats from `RESET_PC`.
- **Wrap:** `ADDR_WIDTH`=4, `RESET_PC`=0x38 → ID sequence is word 14, word 15, word 0, with `ID_PCPlus4` = 0x3C, 0x40, 0x44.
